// File: rtl/deserializador_pkg.sv
// Shared types and widths for the SD-T3 serial front stage and the queue it feeds.
package deserializador_pkg;
   typedef enum logic {COLLECT, WAIT_ACK} deser_state_t;
   localparam int WORD_W = 8;
endpackage

// File: rtl/deserializador.sv
// Serial-to-parallel stage: collects WIDTH bits MSB-first, then holds the word
// with a level data_ready until the consumer acknowledges it.
module deserializador
   import deserializador_pkg::*;
#(
   parameter int WIDTH = WORD_W
) (
   input  logic             clock_100khz,
   input  logic             reset,
   input  logic             data_in,
   input  logic             write_in,
   input  logic             ack_in,
   output logic [WIDTH-1:0] data_out,
   output logic             data_ready,
   output logic             status_out
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   deser_state_t     state;
   // Only WIDTH-1 history bits are kept; the oldest bit would shift out unread.
   logic [WIDTH-2:0] shreg;
   logic [CW-1:0]    bit_cnt;
   logic [WIDTH-1:0] next_word;

   assign next_word = {shreg, data_in};

   always_ff @(posedge clock_100khz) begin
      if (!reset) begin
         state      <= COLLECT;
         shreg      <= '0;
         bit_cnt    <= '0;
         data_out   <= '0;
         data_ready <= 1'b0;
         status_out <= 1'b0;
      end else begin
         case (state)
            COLLECT: begin
               if (write_in) begin
                  shreg <= next_word[WIDTH-2:0];
                  if (bit_cnt == LAST) begin
                     data_out   <= next_word;
                     data_ready <= 1'b1;
                     status_out <= 1'b1;
                     bit_cnt    <= '0;
                     state      <= WAIT_ACK;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end
            WAIT_ACK: begin
               // Bits arriving here are dropped; data_out keeps the word after ack.
               if (ack_in) begin
                  data_ready <= 1'b0;
                  status_out <= 1'b0;
                  state      <= COLLECT;
               end
            end
            default: state <= COLLECT;
         endcase
      end
   end

endmodule

// File: tb/tb_deserializador.sv
// Directed bench for deserializador: hand-computed words, gaps, resets and ack races.
module tb_deserializador;
   import deserializador_pkg::*;

   logic              clock_100khz = 1'b0;
   logic              reset = 1'b0;
   logic              data_in = 1'b0;
   logic              write_in = 1'b0;
   logic              ack_in = 1'b0;
   logic [WORD_W-1:0] data_out;
   logic              data_ready;
   logic              status_out;

   int n_tests = 0;
   int n_fail  = 0;

   deserializador #(.WIDTH(WORD_W)) dut (
      .clock_100khz(clock_100khz),
      .reset       (reset),
      .data_in     (data_in),
      .write_in    (write_in),
      .ack_in      (ack_in),
      .data_out    (data_out),
      .data_ready  (data_ready),
      .status_out  (status_out)
   );

   always #5 clock_100khz = ~clock_100khz;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one edge and settle 1 time unit after it.
   task automatic tick();
      @(posedge clock_100khz);
      #1;
   endtask

   task automatic send_bit(input logic b);
      write_in = 1'b1;
      data_in  = b;
      tick();
      write_in = 1'b0;
      data_in  = 1'b0;
   endtask

   task automatic send_word(input logic [7:0] w);
      for (int i = 7; i >= 0; i--) begin
         send_bit(w[i]);
         if (i == 1) chk("ready_before_last_bit", {31'd0, data_ready}, 32'd0);
      end
   endtask

   task automatic ack();
      ack_in = 1'b1;
      tick();
      ack_in = 1'b0;
   endtask

   logic [7:0] gw;

   initial begin
      // Reset held 3 cycles with random strobes.
      for (int i = 0; i < 3; i++) begin
         write_in = 1'($urandom_range(0, 1));
         data_in  = 1'($urandom_range(0, 1));
         tick();
         chk("reset_outputs", {22'd0, data_out, data_ready, status_out}, 32'd0);
      end
      write_in = 1'b0;
      data_in  = 1'b0;
      reset    = 1'b1;
      tick();
      chk("idle_after_reset", {22'd0, data_out, data_ready, status_out}, 32'd0);

      // Contiguous word.
      send_word(8'hB2);
      chk("b2_data", {24'd0, data_out}, 32'hB2);
      chk("b2_ready_status", {30'd0, data_ready, status_out}, 32'h3);

      // Bits offered while waiting are dropped.
      for (int i = 0; i < 8; i++) send_bit(1'b1);
      chk("b2_hold_data", {24'd0, data_out}, 32'hB2);
      chk("b2_hold_ready", {31'd0, data_ready}, 32'd1);

      ack();
      chk("ack_ready_low", {30'd0, data_ready, status_out}, 32'd0);
      chk("ack_keeps_data", {24'd0, data_out}, 32'hB2);

      // Next word immediately after ack.
      send_word(8'h5A);
      chk("5a_data", {24'd0, data_out}, 32'h5A);
      chk("5a_ready", {31'd0, data_ready}, 32'd1);
      ack();

      // Gapped word, 0..3 idle cycles before each bit.
      gw = 8'hC3;
      for (int i = 7; i >= 0; i--) begin
         for (int g = 0; g < (7 - i) % 4; g++) tick();
         send_bit(gw[i]);
         if (i == 1) chk("gap_ready_before_last", {31'd0, data_ready}, 32'd0);
      end
      chk("gap_ready_1cyc", {30'd0, data_ready, status_out}, 32'h3);
      chk("gap_data", {24'd0, data_out}, 32'hC3);
      ack();

      // Mid-word reset, with strobe and ack asserted to check priority.
      for (int i = 0; i < 5; i++) send_bit(1'b1);
      reset    = 1'b0;
      write_in = 1'b1;
      data_in  = 1'b1;
      ack_in   = 1'b1;
      tick();
      reset    = 1'b1;
      write_in = 1'b0;
      data_in  = 1'b0;
      ack_in   = 1'b0;
      chk("midword_reset_outputs", {22'd0, data_out, data_ready, status_out}, 32'd0);
      send_word(8'h00);
      chk("after_reset_data", {24'd0, data_out}, 32'h00);
      chk("after_reset_ready", {31'd0, data_ready}, 32'd1);

      // Reset in WAIT_ACK drops the word.
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk("reset_in_wait", {30'd0, data_ready, status_out}, 32'd0);
      send_word(8'hFF);
      chk("ff_data", {24'd0, data_out}, 32'hFF);

      // Write and ack together in WAIT_ACK: ack wins, bit dropped.
      write_in = 1'b1;
      data_in  = 1'b1;
      ack_in   = 1'b1;
      tick();
      write_in = 1'b0;
      data_in  = 1'b0;
      ack_in   = 1'b0;
      chk("simul_ack_taken", {30'd0, data_ready, status_out}, 32'd0);

      // 8'h81 with ack held during the 2nd bit in COLLECT: bit still captured.
      gw = 8'h81;
      for (int i = 7; i >= 0; i--) begin
         ack_in = (i == 6);
         send_bit(gw[i]);
      end
      ack_in = 1'b0;
      chk("81_data", {24'd0, data_out}, 32'h81);
      chk("81_ready", {31'd0, data_ready}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
